// File: rtl/ext_sram_responder_if.sv
// Multiplexed 16-bit external SRAM bus between the EXT_SRAM frontend (master) and a responder (slave).
interface ext_sram_responder_if;
    logic        valid;
    logic        rw;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        ready;
    logic        miss;

    modport master (
        output valid, rw, bus_in,
        input  bus_out, bus_oe, ready, miss
    );

    modport slave (
        input  valid, rw, bus_in,
        output bus_out, bus_oe, ready, miss
    );
endinterface

// File: rtl/ext_sram_responder.sv
// Responder for 3-beat (addr hi, addr lo, data) external SRAM transactions backed by a local array.
// Optional data-beat wait states are enabled by defining EXT_SRAM_RESP_WAIT_EN.
module ext_sram_responder #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          WAIT_CYC  = 2
) (
    input logic                clk,
    input logic                rst_n,
    ext_sram_responder_if.slave bus
);

    // ALO means "beat 1 captured": IDLE consumes beat 1 itself, so there is no separate AHI state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALO  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            addr_hi;
    logic                   rw_q;
    logic                   hit_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic                   oe_q;
    logic                   miss_q;
    logic [15:0]            rd_word;
    logic                   ready_int;
    logic                   capture_hi;
    logic                   capture_lo;
    logic                   complete;
    logic [31:0]            offset;
    logic                   hit_now;
    logic [ADDR_BITS-1:0]   idx_now;

    logic [15:0] mem [2**ADDR_BITS];

    // BASE is aligned, so the window check reduces to the offset's upper bits being zero.
    always_comb begin
        offset  = {addr_hi, bus.bus_in} - BASE;
        hit_now = (offset[31:ADDR_BITS] == '0);
        idx_now = offset[ADDR_BITS-1:0];
    end

    always_comb begin
        state_nxt  = state;
        capture_hi = 1'b0;
        capture_lo = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid) begin
                    capture_hi = 1'b1;
                    state_nxt  = ALO;
                end
            end
            ALO: begin
                if (bus.valid) begin
                    capture_lo = 1'b1;
                    state_nxt  = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!bus.valid) begin
                    state_nxt = IDLE;
                end else if (ready_int) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_hi <= '0;
            rw_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            oe_q    <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            miss_q <= complete & ~hit_q;
            if (capture_hi) begin
                addr_hi <= bus.bus_in;
                rw_q    <= bus.rw;
            end
            if (capture_lo) begin
                hit_q <= hit_now;
                idx_q <= idx_now;
                oe_q  <= ~rw_q & hit_now;
            end else if (state_nxt != DATA) begin
                oe_q <= 1'b0;
            end
        end
    end

    // Array is never reset; completion and capture are already gated off by the reset state.
    always_ff @(posedge clk) begin
        if (capture_lo && !rw_q && hit_now) begin
            rd_word <= mem[idx_now];
        end
        if (complete && rw_q && hit_q) begin
            mem[idx_q] <= bus.bus_in;
        end
    end

`ifdef EXT_SRAM_RESP_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (capture_lo) begin
            wait_cnt <= 4'(WAIT_CYC);
        end else if (state_nxt != DATA) begin
            wait_cnt <= '0;
        end else if (bus.valid && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign ready_int = (wait_cnt == 4'd0);
`else
    logic unused_wait_cyc;
    assign unused_wait_cyc = ^4'(WAIT_CYC);
    assign ready_int       = 1'b1;
`endif

    assign bus.ready   = ready_int;
    assign bus.bus_oe  = oe_q;
    assign bus.bus_out = oe_q ? rd_word : 16'h0000;
    assign bus.miss    = miss_q;

endmodule

// File: tb/tb_ext_sram_responder.sv
// Randomized bench for ext_sram_responder against a word-addressed memory model of the window.
module tb_ext_sram_responder;

    localparam int          ADDR_BITS = 12;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          WAIT_CYC  = 2;
`ifdef EXT_SRAM_RESP_WAIT_EN
    localparam int EXP_WAIT = WAIT_CYC;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model_mem [int unsigned];

    always #5 clk = ~clk;

    ext_sram_responder_if bus ();

    ext_sram_responder #(
        .ADDR_BITS(ADDR_BITS),
        .BASE     (BASE),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < (32'd1 << ADDR_BITS);
    endfunction

    function automatic int unsigned word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off) & ((1 << ADDR_BITS) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) step();
    endtask

    // One transaction; valid stays high on completion so the next call is back-to-back.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [15:0] data,
                                 input bit abort_alo, input bit abort_data);
        bit          hit;
        bit          known;
        int unsigned idx;
        logic [15:0] exp_rd;
        hit    = in_window(addr);
        idx    = word_idx(addr);
        known  = hit && model_mem.exists(idx);
        exp_rd = known ? model_mem[idx] : 16'h0000;

        bus.valid  = 1'b1;
        bus.rw     = wr;
        bus.bus_in = addr[31:16];
        step();
        checkOutput("oe_beat2", bus.bus_oe, 0);
        bus.rw     = 1'($urandom);
        bus.bus_in = addr[15:0];
        if (abort_alo) begin
            bus.valid = 1'b0;
            step();
            checkOutput("oe_abort_alo", bus.bus_oe, 0);
            checkOutput("miss_abort_alo", bus.miss, 0);
            return;
        end
        step();
        bus.rw     = 1'($urandom);
        bus.bus_in = wr ? data : 16'($urandom);
        checkOutput("oe_beat3", bus.bus_oe, !wr && hit);
        if (abort_data) begin
            bus.valid = 1'b0;
            step();
            checkOutput("oe_abort_data", bus.bus_oe, 0);
            step();
            checkOutput("miss_abort_data", bus.miss, 0);
            return;
        end
        for (int w = 0; w < EXP_WAIT; w++) begin
            checkOutput("ready_wait", bus.ready, 0);
            checkOutput("oe_wait", bus.bus_oe, !wr && hit);
            if (!wr && known) checkOutput("rdata_wait", bus.bus_out, exp_rd);
            step();
        end
        checkOutput("ready_data", bus.ready, 1);
        if (!wr && known) checkOutput("rdata", bus.bus_out, exp_rd);
        if (!hit) checkOutput("out_miss_zero", bus.bus_out, 0);
        step();
        checkOutput("miss", bus.miss, !hit);
        checkOutput("oe_after", bus.bus_oe, 0);
        if (wr && hit) model_mem[idx] = data;
    endtask

    // Reset pulse while in the data beat; any pending write must be dropped.
    task automatic resetInData(input bit wr, input logic [31:0] addr, input logic [15:0] data);
        bus.valid  = 1'b1;
        bus.rw     = wr;
        bus.bus_in = addr[31:16];
        step();
        bus.bus_in = addr[15:0];
        step();
        bus.bus_in = data;
        checkOutput("oe_pre_reset", bus.bus_oe, !wr && in_window(addr));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("oe_in_reset", bus.bus_oe, 0);
        checkOutput("out_in_reset", bus.bus_out, 0);
        checkOutput("ready_in_reset", bus.ready, 1);
        checkOutput("miss_in_reset", bus.miss, 0);
        bus.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n      = 1'b0;
        bus.valid  = 1'b0;
        bus.rw     = 1'b0;
        bus.bus_in = 16'h0000;
        #12;
        checkOutput("rst_oe", bus.bus_oe, 0);
        checkOutput("rst_out", bus.bus_out, 0);
        checkOutput("rst_ready", bus.ready, 1);
        checkOutput("rst_miss", bus.miss, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        applyStimulus(1'b1, 32'h0000_0010, 16'hA5A5, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 32'h0000_0010, 16'h0000, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'(i), 16'(16'h1000 + i * 16'h0111), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 32'(i), 16'h0000, 1'b0, 1'b0);
        idle(1);

        applyStimulus(1'b1, 32'h0000_0020, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0020, 16'h2222, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0020, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0020, 16'h3333, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0000_0020, 16'h0000, 1'b0, 1'b0);

        applyStimulus(1'b1, 32'h0000_0FFF, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 16'hDEAD, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0FFF, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_1000, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0);
        idle(1);

        resetInData(1'b0, 32'h0000_0010, 16'h0000);
        applyStimulus(1'b0, 32'h0000_0010, 16'h0000, 1'b0, 1'b0);
        idle(1);
        resetInData(1'b1, 32'h0000_0010, 16'h7777);
        applyStimulus(1'b0, 32'h0000_0010, 16'h0000, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 32'(i), 16'($urandom), 1'b0, 1'b0);
        idle(1);

        for (int n = 0; n < 120; n++) begin
            int          sel;
            logic [31:0] addr;
            bit          wr;
            int          ab;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       addr = 32'($urandom_range(0, 63));
            else if (sel == 7) addr = $urandom;
            else               addr = 32'h0000_1000 + 32'($urandom_range(0, 15));
            wr = 1'($urandom);
            ab = int'($urandom_range(0, 11));
            applyStimulus(wr, addr, 16'($urandom), ab == 0, ab == 1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
